neosd_cmd_fsm: RTL and testbench

NEOSD_CMD_FSM -- requirements
Module: neosd_cmd_fsm

---
 rtl/neosd_pkg.sv | 30 +++
 rtl/neosd_crc7.sv | 26 ++
 rtl/neosd_cmd_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_neosd_cmd_fsm.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neosd_pkg.sv
// Shared definitions for the NEOSD command-line engine: state codes, response
// types, CRC7 polynomial and default SD-clock timing limits.
package neosd_pkg;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_PRE  = 3'd1;
   localparam state_t S_TX   = 3'd2;
   localparam state_t S_NCR  = 3'd3;
   localparam state_t S_RX   = 3'd4;
   localparam state_t S_HOLD = 3'd5;
   localparam state_t S_NCC  = 3'd6;

   typedef logic [1:0] rsp_type_t;
   localparam rsp_type_t RSP_NONE = 2'd0;
   localparam rsp_type_t RSP_R1   = 2'd1;
   localparam rsp_type_t RSP_R3   = 2'd2;
   localparam rsp_type_t RSP_RSVD = 2'd3;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam int unsigned NCR_MAX_DEF = 64;
   localparam int unsigned NCC_MIN_DEF = 8;

   // the reserved encoding behaves exactly like "no response"
   function automatic rsp_type_t norm_rsp_type(input rsp_type_t t);
      return (t == RSP_RSVD) ? RSP_NONE : t;
   endfunction

endpackage

// File: rtl/neosd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one data bit per enabled cycle, MSB first.
module neosd_crc7
   import neosd_pkg::*;
(
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       din_i,
   output logic [6:0] crc_o
);

   logic fb;
   assign fb = crc_o[6] ^ din_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         crc_o <= '0;
      end else if (clr_i) begin
         crc_o <= '0;
      end else if (en_i) begin
         crc_o <= {crc_o[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
   end

endmodule

// File: rtl/neosd_cmd_fsm.sv
// SD CMD-line engine: sends a 48-bit command frame, optionally receives a
// 48-bit response, and manages the SD clock request/stall around it.
module neosd_cmd_fsm
   import neosd_pkg::*;
#(
   parameter int unsigned NCR_MAX = NCR_MAX_DEF,
   parameter int unsigned NCC_MIN = NCC_MIN_DEF
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        clkstrb_i,
   input  logic        sd_clk_en_i,
   output logic        sd_clk_req_o,
   output logic        sd_clk_stall_o,
   input  logic        cmd_start_i,
   input  logic [5:0]  cmd_idx_i,
   input  logic [31:0] cmd_arg_i,
   input  logic [1:0]  rsp_type_i,
   output logic        busy_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ack_i,
   output logic [5:0]  rsp_idx_o,
   output logic [31:0] rsp_arg_o,
   output logic        err_timeout_o,
   output logic        err_crc_o,
   output logic        err_frame_o,
   output logic        sd_cmd_o,
   output logic        sd_cmd_oe_o,
   input  logic        sd_cmd_i
);

   localparam int unsigned CW = $clog2(NCR_MAX + NCC_MIN + 48) + 1;

   state_t      state;
   rsp_type_t   rsp_type;
   logic [CW-1:0] cnt;
   logic [39:0] tx_sreg;
   logic [45:0] rx_sreg;
   logic [6:0]  tx_crc, rx_crc;

   logic tick, ack, crc_clr, tx_crc_en, rx_crc_en;

   assign tick    = clkstrb_i & sd_clk_en_i;
   assign ack     = rsp_ack_i & rsp_valid_o;
   assign crc_clr = (state == S_IDLE) & cmd_start_i;

   // TX CRC is fed exactly the 40 header bits as they go onto the line
   assign tx_crc_en = tick & ((state == S_PRE) | ((state == S_TX) & (cnt > CW'(8))));
   // RX CRC is fed the start bit (seen in NCR) plus the next 39 bits
   assign rx_crc_en = tick & (((state == S_NCR) & ~sd_cmd_i) |
                              ((state == S_RX) & (cnt < CW'(40))));

   assign busy_o         = (state != S_IDLE);
   assign sd_clk_stall_o = (state == S_HOLD);

   neosd_crc7 u_crc_tx (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clr_i  (crc_clr),
      .en_i   (tx_crc_en),
      .din_i  (tx_sreg[39]),
      .crc_o  (tx_crc)
   );

   neosd_crc7 u_crc_rx (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clr_i  (crc_clr),
      .en_i   (rx_crc_en),
      .din_i  (sd_cmd_i),
      .crc_o  (rx_crc)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state         <= S_IDLE;
         rsp_type      <= RSP_NONE;
         cnt           <= '0;
         tx_sreg       <= '0;
         rx_sreg       <= '0;
         sd_clk_req_o  <= 1'b0;
         sd_cmd_o      <= 1'b1;
         sd_cmd_oe_o   <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_idx_o     <= '0;
         rsp_arg_o     <= '0;
         err_timeout_o <= 1'b0;
         err_crc_o     <= 1'b0;
         err_frame_o   <= 1'b0;
      end else begin
         if (ack) begin
            rsp_valid_o   <= 1'b0;
            err_timeout_o <= 1'b0;
            err_crc_o     <= 1'b0;
            err_frame_o   <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (cmd_start_i) begin
                  tx_sreg       <= {2'b01, cmd_idx_i, cmd_arg_i};
                  rsp_type      <= norm_rsp_type(rsp_type_i);
                  cnt           <= '0;
                  sd_clk_req_o  <= 1'b1;
                  sd_cmd_o      <= 1'b1;
                  sd_cmd_oe_o   <= 1'b0;
                  rsp_valid_o   <= 1'b0;
                  err_timeout_o <= 1'b0;
                  err_crc_o     <= 1'b0;
                  err_frame_o   <= 1'b0;
                  state         <= S_PRE;
               end
            end

            S_PRE: begin
               if (tick) begin
                  sd_cmd_oe_o <= 1'b1;
                  sd_cmd_o    <= tx_sreg[39];
                  tx_sreg     <= {tx_sreg[38:0], 1'b0};
                  cnt         <= CW'(47);
                  state       <= S_TX;
               end
            end

            // cnt holds the index of the bit currently on the line
            S_TX: begin
               if (tick) begin
                  if (cnt == '0) begin
                     sd_cmd_oe_o <= 1'b0;
                     sd_cmd_o    <= 1'b1;
                     cnt         <= '0;
                     if (rsp_type == RSP_NONE) begin
                        rsp_valid_o <= 1'b1;
                        state       <= S_NCC;
                     end else begin
                        state <= S_NCR;
                     end
                  end else begin
                     cnt <= cnt - CW'(1);
                     if (cnt == CW'(8)) begin
                        // header done: reuse the shifter for CRC tail + end bit
                        sd_cmd_o <= tx_crc[6];
                        tx_sreg  <= {tx_crc[5:0], 1'b1, 33'd0};
                     end else begin
                        sd_cmd_o <= tx_sreg[39];
                        tx_sreg  <= {tx_sreg[38:0], 1'b0};
                     end
                  end
               end
            end

            S_NCR: begin
               if (tick) begin
                  if (!sd_cmd_i) begin
                     rx_sreg <= '0;
                     cnt     <= CW'(1);
                     state   <= S_RX;
                  end else if (cnt == CW'(NCR_MAX - 1)) begin
                     err_timeout_o <= 1'b1;
                     rsp_valid_o   <= 1'b1;
                     state         <= S_HOLD;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end

            // rx_sreg holds frame bits 46..1; sd_cmd_i is the end bit on the last tick
            S_RX: begin
               if (tick) begin
                  if (cnt == CW'(47)) begin
                     err_frame_o <= rx_sreg[45] | ~sd_cmd_i;
                     err_crc_o   <= (rsp_type == RSP_R1) & (rx_sreg[6:0] != rx_crc);
                     rsp_idx_o   <= rx_sreg[44:39];
                     rsp_arg_o   <= rx_sreg[38:7];
                     rsp_valid_o <= 1'b1;
                     state       <= S_HOLD;
                  end else begin
                     rx_sreg <= {rx_sreg[44:0], sd_cmd_i};
                     cnt     <= cnt + CW'(1);
                  end
               end
            end

            S_HOLD: begin
               if (ack) begin
                  cnt   <= '0;
                  state <= S_NCC;
               end
            end

            S_NCC: begin
               if (tick) begin
                  if (cnt == CW'(NCC_MIN - 1)) begin
                     sd_clk_req_o <= 1'b0;
                     cnt          <= '0;
                     state        <= S_IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neosd_cmd_fsm.sv
// Directed bench for neosd_cmd_fsm: models the SD clock generator and card,
// checks TX frames, response capture, timing limits and reset behaviour.
module tb_neosd_cmd_fsm;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        clkstrb;
   logic        sd_clk_en;
   logic        sd_clk_req, sd_clk_stall;
   logic        cmd_start = 1'b0;
   logic [5:0]  cmd_idx = '0;
   logic [31:0] cmd_arg = '0;
   logic [1:0]  rsp_type = '0;
   logic        busy, rsp_valid;
   logic        rsp_ack = 1'b0;
   logic [5:0]  rsp_idx;
   logic [31:0] rsp_arg;
   logic        err_timeout, err_crc, err_frame;
   logic        sd_cmd_o, sd_cmd_oe;
   logic        sd_cmd_i = 1'b1;
   logic        pause = 1'b0;
   logic [1:0]  div = '0;

   int n_tests = 0;
   int n_fail  = 0;
   int tick_cnt = 0;
   bit hung = 0;

   neosd_cmd_fsm #(.NCR_MAX(64), .NCC_MIN(8)) dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .clkstrb_i      (clkstrb),
      .sd_clk_en_i    (sd_clk_en),
      .sd_clk_req_o   (sd_clk_req),
      .sd_clk_stall_o (sd_clk_stall),
      .cmd_start_i    (cmd_start),
      .cmd_idx_i      (cmd_idx),
      .cmd_arg_i      (cmd_arg),
      .rsp_type_i     (rsp_type),
      .busy_o         (busy),
      .rsp_valid_o    (rsp_valid),
      .rsp_ack_i      (rsp_ack),
      .rsp_idx_o      (rsp_idx),
      .rsp_arg_o      (rsp_arg),
      .err_timeout_o  (err_timeout),
      .err_crc_o      (err_crc),
      .err_frame_o    (err_frame),
      .sd_cmd_o       (sd_cmd_o),
      .sd_cmd_oe_o    (sd_cmd_oe),
      .sd_cmd_i       (sd_cmd_i)
   );

   always #5 clk = ~clk;

   // clock generator model: strobe every 4th cycle, gated by request/stall/pause
   always @(negedge clk) div = div + 2'd1;
   assign clkstrb   = (div == 2'd3);
   assign sd_clk_en = sd_clk_req & ~sd_clk_stall & ~pause;

   initial begin
      #500000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // returns at posedge+1 right after the next bit tick
   task automatic wait_tick();
      bit t;
      int guard;
      t = 0;
      guard = 0;
      if (hung) return;
      while (!t) begin
         @(negedge clk); #1;
         t = clkstrb & sd_clk_en;
         @(posedge clk); #1;
         guard++;
         if (!t && guard > 400) begin
            hung = 1;
            n_tests++;
            n_fail++;
            $error("FAIL tick_wait: observed no bit tick, expected one within 400 cycles");
            return;
         end
      end
      tick_cnt++;
   endtask

   task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
      @(negedge clk);
      cmd_idx = idx; cmd_arg = arg; rsp_type = typ; cmd_start = 1'b1;
      @(posedge clk); #1;
      cmd_start = 1'b0;
   endtask

   task automatic run_tx(input int pause_at, output logic [47:0] bits);
      int n;
      n = 0;
      bits = '0;
      for (int k = 0; k < 60; k++) begin
         wait_tick();
         if (sd_cmd_oe) begin
            bits = {bits[46:0], sd_cmd_o};
            n++;
            if (n == pause_at) begin
               pause = 1'b1;
               repeat (20) @(posedge clk);
               #1 pause = 1'b0;
            end
         end else if (n > 0) begin
            break;
         end
      end
      chk("tx_bitcount", 48'(n), 48'd48);
   endtask

   task automatic card_rsp(input logic [47:0] fr, input int delay, input int nbits);
      repeat (delay) wait_tick();
      for (int i = 47; i > 47 - nbits; i--) begin
         sd_cmd_i = fr[i];
         wait_tick();
      end
      if (nbits == 48) sd_cmd_i = 1'b1;
   endtask

   task automatic ack_rsp();
      rsp_ack = 1'b1;
      @(posedge clk); #1;
      rsp_ack = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 50 && !hung) begin
         wait_tick();
         n++;
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ctl"},
          48'({sd_cmd_o, sd_cmd_oe, sd_clk_req, sd_clk_stall, busy, rsp_valid,
               err_timeout, err_crc, err_frame}),
          48'b1_0000_0000);
      chk({tag, "_idxarg"}, 48'({rsp_idx, rsp_arg}), 48'd0);
   endtask

   initial begin
      logic [47:0] bits;
      int n;

      repeat (3) @(posedge clk); #1;
      check_reset("reset");
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;

      // CMD0, no response
      start_cmd(6'd0, 32'h0, 2'd0);
      chk("cmd0_busy_req", 48'({busy, sd_clk_req}), 48'b11);
      run_tx(0, bits);
      chk("cmd0_frame", bits, 48'h40_0000_0000_95);
      chk("cmd0_valid_noerr", 48'({rsp_valid, err_timeout, err_crc, err_frame}), 48'b1000);
      wait_idle(n);
      chk("cmd0_ncc_ticks", 48'(n), 48'd8);
      chk("cmd0_req_valid", 48'({sd_clk_req, busy, rsp_valid}), 48'b001);
      ack_rsp();
      chk("cmd0_ack", 48'(rsp_valid), 48'd0);

      // CMD8 with valid R7 echo
      start_cmd(6'd8, 32'h0000_01AA, 2'd1);
      run_tx(0, bits);
      chk("cmd8_frame", bits, 48'h48_0000_01AA_87);
      card_rsp(48'h08_0000_01AA_13, 2, 48);
      chk("cmd8_flags", 48'({rsp_valid, err_timeout, err_crc, err_frame}), 48'b1000);
      chk("cmd8_idx", 48'(rsp_idx), 48'd8);
      chk("cmd8_arg", 48'(rsp_arg), 48'h0000_01AA);
      repeat (10) @(posedge clk); #1;
      chk("cmd8_stall_hold", 48'({sd_clk_stall, sd_clk_req, rsp_valid}), 48'b111);
      start_cmd(6'd5, 32'hFFFF_FFFF, 2'd0);
      chk("cmd8_start_ignored", 48'({sd_clk_stall, rsp_valid}), 48'b11);
      ack_rsp();
      chk("cmd8_ack", 48'({rsp_valid, sd_clk_stall}), 48'b00);
      wait_idle(n);
      chk("cmd8_ncc_ticks", 48'(n), 48'd8);

      // response timeout
      start_cmd(6'd8, 32'h0000_01AA, 2'd1);
      run_tx(0, bits);
      repeat (63) wait_tick();
      chk("to_before", 48'({rsp_valid, err_timeout}), 48'b00);
      wait_tick();
      chk("to_at_64", 48'({rsp_valid, err_timeout, sd_clk_stall}), 48'b111);
      ack_rsp();
      wait_idle(n);

      // corrupted CRC, type 1
      start_cmd(6'd8, 32'h0000_01AA, 2'd1);
      run_tx(0, bits);
      card_rsp(48'h08_0000_01AA_11, 3, 48);
      chk("crcbad_r1", 48'({rsp_valid, err_timeout, err_crc, err_frame}), 48'b1010);
      ack_rsp();
      wait_idle(n);

      // same frame, type 2: no CRC check
      start_cmd(6'd8, 32'h0000_01AA, 2'd2);
      run_tx(0, bits);
      card_rsp(48'h08_0000_01AA_11, 0, 48);
      chk("crcbad_r3", 48'({rsp_valid, err_timeout, err_crc, err_frame}), 48'b1000);
      chk("crcbad_r3_idxarg", 48'({rsp_idx, rsp_arg}), 48'({6'd8, 32'h0000_01AA}));
      ack_rsp();
      wait_idle(n);

      // transmission bit set: frame error
      start_cmd(6'd8, 32'h0000_01AA, 2'd2);
      run_tx(0, bits);
      card_rsp(48'h48_0000_01AA_13, 1, 48);
      chk("frame_err", 48'({rsp_valid, err_timeout, err_crc, err_frame}), 48'b1001);
      ack_rsp();
      wait_idle(n);

      // clock enable dropped for 20 cycles mid-TX
      start_cmd(6'd8, 32'h0000_01AA, 2'd0);
      run_tx(20, bits);
      chk("pause_frame", bits, 48'h48_0000_01AA_87);
      wait_idle(n);
      chk("pause_ncc_ticks", 48'(n), 48'd8);
      ack_rsp();

      // reset while receiving bit 20
      start_cmd(6'd8, 32'h0000_01AA, 2'd1);
      run_tx(0, bits);
      card_rsp(48'h08_0000_01AA_13, 2, 20);
      sd_cmd_i = 1'b1;
      rstn = 1'b0;
      #2;
      check_reset("rx_reset");
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      start_cmd(6'd0, 32'h0, 2'd0);
      run_tx(0, bits);
      chk("post_reset_frame", bits, 48'h40_0000_0000_95);
      wait_idle(n);
      chk("post_reset_ncc", 48'({8'(n), rsp_valid, err_timeout, err_crc, err_frame}),
          48'({8'd8, 4'b1000}));
      ack_rsp();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
